// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: FSM states, Zicsr funct3 codes
// and funct3 classification helpers.
package csr_access_unit_pkg;

  localparam int MXLEN = 32;

  localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

  localparam logic [2:0] INST_CSRRW  = 3'b001;
  localparam logic [2:0] INST_CSRRS  = 3'b010;
  localparam logic [2:0] INST_CSRRC  = 3'b011;
  localparam logic [2:0] INST_CSRRWI = 3'b101;
  localparam logic [2:0] INST_CSRRSI = 3'b110;
  localparam logic [2:0] INST_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_WB   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // 000 and 100 are the only unassigned codes in the Zicsr funct3 space.
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[1:0] != 2'b00;
  endfunction

  function automatic logic f3_is_rw(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic f3_is_imm(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Instruction handshake plus CSR bus of the access unit. The slave modport is
// the access unit itself; the master modport is its environment (decode + CSR file).
interface csr_access_unit_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [2:0]      i_funct3;
  logic [11:0]     i_csr_addr;
  logic [4:0]      i_rs1_addr_uimm;
  logic [4:0]      i_rd_addr;
  logic [XLEN-1:0] i_rs1_data;
  logic            o_csr_req;
  logic            o_csr_we;
  logic [11:0]     o_csr_addr;
  logic [XLEN-1:0] o_csr_wdata;
  logic            i_csr_ack;
  logic [XLEN-1:0] i_csr_rdata;
  logic            i_csr_err;
  logic            o_rd_we;
  logic [4:0]      o_rd_addr;
  logic [XLEN-1:0] o_rd_data;
  logic            o_illegal;

  modport slave (
    input  i_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr, i_rs1_data,
    input  i_csr_ack, i_csr_rdata, i_csr_err,
    output o_ready, o_csr_req, o_csr_we, o_csr_addr, o_csr_wdata,
    output o_rd_we, o_rd_addr, o_rd_data, o_illegal
  );

  modport master (
    output i_valid, i_funct3, i_csr_addr, i_rs1_addr_uimm, i_rd_addr, i_rs1_data,
    output i_csr_ack, i_csr_rdata, i_csr_err,
    input  o_ready, o_csr_req, o_csr_we, o_csr_addr, o_csr_wdata,
    input  o_rd_we, o_rd_addr, o_rd_data, o_illegal
  );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr execute-stage initiator: read-modify-write on the CSR bus, old value to rd.
// Optional bus timeout enabled by defining CSR_TIMEOUT_EN.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN           = MXLEN,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               i_clk,
  input logic               i_nrst,
  csr_access_unit_if.slave  bus
);

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_src;
  logic [XLEN-1:0] r_old;
  logic            r_wr_need;
  logic            r_rd_done;

  logic            r_ready;
  logic            r_csr_req;
  logic            r_csr_we;
  logic [11:0]     r_csr_addr;
  logic [XLEN-1:0] r_csr_wdata;
  logic            r_rd_we;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_data;
  logic            r_illegal;

  logic            w_xfer;
  logic            w_wr_skip;
  logic            w_rd_skip;
  logic            w_ro_viol;
  logic [XLEN-1:0] w_src;
  logic            w_timeout;

  function automatic logic [XLEN-1:0] f_wdata(input logic [2:0]      f3,
                                              input logic [XLEN-1:0] old,
                                              input logic [XLEN-1:0] s);
    case (f3[1:0])
      2'b10:   return old | s;
      2'b11:   return old & ~s;
      default: return s;
    endcase
  endfunction

  assign w_xfer    = bus.i_valid & r_ready;
  // Skip decisions look at the rs1/uimm and rd fields, never at register data.
  assign w_wr_skip = !f3_is_rw(bus.i_funct3) && (bus.i_rs1_addr_uimm == 5'd0);
  assign w_rd_skip = f3_is_rw(bus.i_funct3) && (bus.i_rd_addr == 5'd0);
  assign w_ro_viol = (bus.i_csr_addr[11:10] == CSR_RO_PREFIX) && !w_wr_skip;
  assign w_src     = f3_is_imm(bus.i_funct3) ? {{(XLEN-5){1'b0}}, bus.i_rs1_addr_uimm}
                                             : bus.i_rs1_data;

`ifdef CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_bus_busy;

  assign w_bus_busy = (r_state == ST_RD) || (r_state == ST_WR);
  assign w_timeout  = w_bus_busy && !bus.i_csr_ack &&
                      (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // An ack moves RD->WR or leaves the bus, so clearing on ack covers entry to WR.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_tmo_cnt <= '0;
    end else if (!w_bus_busy || bus.i_csr_ack) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`else
  // No counter in this build; the bus wait is unbounded.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state     <= ST_IDLE;
      r_funct3    <= '0;
      r_rd        <= '0;
      r_src       <= '0;
      r_old       <= '0;
      r_wr_need   <= 1'b0;
      r_rd_done   <= 1'b0;
      r_ready     <= 1'b1;
      r_csr_req   <= 1'b0;
      r_csr_we    <= 1'b0;
      r_csr_addr  <= '0;
      r_csr_wdata <= '0;
      r_rd_we     <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_data   <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_rd_we   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_funct3   <= bus.i_funct3;
            r_rd       <= bus.i_rd_addr;
            r_src      <= w_src;
            r_old      <= '0;
            r_wr_need  <= !w_wr_skip;
            r_rd_done  <= 1'b0;
            r_ready    <= 1'b0;
            if (!f3_legal(bus.i_funct3) || w_ro_viol) begin
              r_state   <= ST_ERR;
              r_illegal <= 1'b1;
            end else begin
              r_csr_req  <= 1'b1;
              r_csr_addr <= bus.i_csr_addr;
              if (w_rd_skip) begin
                r_state     <= ST_WR;
                r_csr_we    <= 1'b1;
                r_csr_wdata <= w_src;
              end else begin
                r_state     <= ST_RD;
                r_csr_we    <= 1'b0;
                r_csr_wdata <= '0;
              end
            end
          end
        end

        ST_RD: begin
          if (bus.i_csr_ack) begin
            r_old     <= bus.i_csr_rdata;
            r_rd_done <= 1'b1;
            if (bus.i_csr_err) begin
              r_state    <= ST_ERR;
              r_illegal  <= 1'b1;
              r_csr_req  <= 1'b0;
              r_csr_addr <= '0;
            end else if (r_wr_need) begin
              r_state     <= ST_WR;
              r_csr_we    <= 1'b1;
              r_csr_wdata <= f_wdata(r_funct3, bus.i_csr_rdata, r_src);
            end else begin
              r_state    <= ST_WB;
              r_csr_req  <= 1'b0;
              r_csr_addr <= '0;
              r_rd_we    <= (r_rd != 5'd0);
              r_rd_addr  <= r_rd;
              r_rd_data  <= bus.i_csr_rdata;
            end
          end else if (w_timeout) begin
            r_state    <= ST_ERR;
            r_illegal  <= 1'b1;
            r_csr_req  <= 1'b0;
            r_csr_addr <= '0;
          end
        end

        ST_WR: begin
          if (bus.i_csr_ack || w_timeout) begin
            r_csr_req   <= 1'b0;
            r_csr_we    <= 1'b0;
            r_csr_addr  <= '0;
            r_csr_wdata <= '0;
            if (!bus.i_csr_ack || bus.i_csr_err) begin
              r_state   <= ST_ERR;
              r_illegal <= 1'b1;
            end else begin
              r_state   <= ST_WB;
              r_rd_we   <= r_rd_done && (r_rd != 5'd0);
              r_rd_addr <= r_rd;
              r_rd_data <= r_old;
            end
          end
        end

        ST_WB: begin
          r_state   <= ST_IDLE;
          r_ready   <= 1'b1;
          r_rd_addr <= '0;
          r_rd_data <= '0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.o_ready     = r_ready;
  assign bus.o_csr_req   = r_csr_req;
  assign bus.o_csr_we    = r_csr_we;
  assign bus.o_csr_addr  = r_csr_addr;
  assign bus.o_csr_wdata = r_csr_wdata;
  assign bus.o_rd_we     = r_rd_we;
  assign bus.o_rd_addr   = r_rd_addr;
  assign bus.o_rd_data   = r_rd_data;
  assign bus.o_illegal   = r_illegal;

endmodule
